// File: rtl/ct_mmu_sysmap_cfg_if.sv
// Lookup, region-table configuration and result signals of the system address map.
// cfg_lock is present only when SYSMAP_CFG_LOCK_EN is defined.
interface ct_mmu_sysmap_cfg_if #(
  parameter int NUM_REGION = 8,
  parameter int ADDR_WIDTH = 28,
  parameter int FLG_WIDTH  = 5
);
  localparam int IDX_WIDTH = $clog2(NUM_REGION);

  logic                  lkup_vld;
  logic [ADDR_WIDTH-1:0] lkup_pa;
  logic                  lkup_flush;
  logic                  cfg_wen;
  logic [IDX_WIDTH-1:0]  cfg_idx;
  logic [ADDR_WIDTH-1:0] cfg_upaddr;
  logic [FLG_WIDTH-1:0]  cfg_flg;
`ifdef SYSMAP_CFG_LOCK_EN
  logic                  cfg_lock;
`endif
  logic [ADDR_WIDTH-1:0] cfg_rd_upaddr;
  logic [FLG_WIDTH-1:0]  cfg_rd_flg;
  logic                  rslt_vld;
  logic [NUM_REGION-1:0] rslt_hit;
  logic [FLG_WIDTH-1:0]  rslt_flg;

  modport slave (
    input  lkup_vld, lkup_pa, lkup_flush,
    input  cfg_wen, cfg_idx, cfg_upaddr, cfg_flg,
`ifdef SYSMAP_CFG_LOCK_EN
    input  cfg_lock,
`endif
    output cfg_rd_upaddr, cfg_rd_flg,
    output rslt_vld, rslt_hit, rslt_flg
  );

  modport master (
    output lkup_vld, lkup_pa, lkup_flush,
    output cfg_wen, cfg_idx, cfg_upaddr, cfg_flg,
`ifdef SYSMAP_CFG_LOCK_EN
    output cfg_lock,
`endif
    input  cfg_rd_upaddr, cfg_rd_flg,
    input  rslt_vld, rslt_hit, rslt_flg
  );
endinterface

// File: rtl/ct_mmu_sysmap_cfg.sv
// Two-stage system address map: physical page number -> region hit vector and attribute flag.
// Optional per-region write lock enabled by defining SYSMAP_CFG_LOCK_EN.
module ct_mmu_sysmap_cfg #(
  parameter int                   NUM_REGION = 8,
  parameter int                   ADDR_WIDTH = 28,
  parameter int                   FLG_WIDTH  = 5,
  parameter logic [FLG_WIDTH-1:0] DEF_FLG    = 5'b10011
) (
  input logic                forever_cpuclk,
  input logic                cpurst,
  ct_mmu_sysmap_cfg_if.slave bus
);
  localparam int IDX_WIDTH = $clog2(NUM_REGION);

  logic [ADDR_WIDTH-1:0] upaddr_q [NUM_REGION];
  logic [ADDR_WIDTH-1:0] upaddr_d [NUM_REGION];
  logic [FLG_WIDTH-1:0]  flg_q    [NUM_REGION];
  logic [FLG_WIDTH-1:0]  flg_d    [NUM_REGION];
  logic [NUM_REGION-1:0] wr_mask_s;
  logic [NUM_REGION-1:0] wen_s;
  logic [ADDR_WIDTH-1:0] rd_upaddr_s;
  logic [FLG_WIDTH-1:0]  rd_flg_s;

  logic [NUM_REGION-1:0] lt_s;
  logic                  s1_vld_d, s1_vld_q;
  logic [NUM_REGION-1:0] s1_lt_d, s1_lt_q;

  logic [NUM_REGION-1:0] hit_s;
  logic                  onehot_s;
  logic [FLG_WIDTH-1:0]  sel_flg_s;
  logic                  rslt_vld_d, rslt_vld_q;
  logic [NUM_REGION-1:0] rslt_hit_d, rslt_hit_q;
  logic [FLG_WIDTH-1:0]  rslt_flg_d, rslt_flg_q;

  function automatic logic is_onehot(input logic [NUM_REGION-1:0] vec);
    return (vec != {NUM_REGION{1'b0}}) &&
           ((vec & (vec - {{(NUM_REGION-1){1'b0}}, 1'b1})) == {NUM_REGION{1'b0}});
  endfunction

`ifdef SYSMAP_CFG_LOCK_EN
  logic [NUM_REGION-1:0] lock_q, lock_d;

  assign wr_mask_s = ~lock_q;
  assign lock_d    = lock_q | (wen_s & {NUM_REGION{bus.cfg_lock}});

  // Lock bits only clear on reset.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      lock_q <= {NUM_REGION{1'b0}};
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  assign wr_mask_s = {NUM_REGION{1'b1}};
`endif

  // Indices at or above NUM_REGION match no region, so such writes drop and readback is zero.
  always_comb begin
    rd_upaddr_s = {ADDR_WIDTH{1'b0}};
    rd_flg_s    = {FLG_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGION; i++) begin
      wen_s[i]    = bus.cfg_wen && (bus.cfg_idx == IDX_WIDTH'(i)) && wr_mask_s[i];
      upaddr_d[i] = wen_s[i] ? bus.cfg_upaddr : upaddr_q[i];
      flg_d[i]    = wen_s[i] ? bus.cfg_flg : flg_q[i];
      rd_upaddr_s = rd_upaddr_s | (upaddr_q[i] & {ADDR_WIDTH{bus.cfg_idx == IDX_WIDTH'(i)}});
      rd_flg_s    = rd_flg_s | (flg_q[i] & {FLG_WIDTH{bus.cfg_idx == IDX_WIDTH'(i)}});
    end
  end

  // Stage 1 compares against the table before any same-cycle write lands.
  always_comb begin
    for (int i = 0; i < NUM_REGION; i++) begin
      lt_s[i] = bus.lkup_pa < upaddr_q[i];
    end
    s1_vld_d = bus.lkup_vld && !bus.lkup_flush;
    s1_lt_d  = lt_s;
  end

  // Stage 2: lower bound of region i is upaddr(i-1); flag comes from the current table.
  always_comb begin
    hit_s     = s1_lt_q & ~{s1_lt_q[NUM_REGION-2:0], 1'b0};
    onehot_s  = is_onehot(hit_s);
    sel_flg_s = {FLG_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGION; i++) begin
      sel_flg_s = sel_flg_s | (flg_q[i] & {FLG_WIDTH{hit_s[i]}});
    end
    rslt_vld_d = s1_vld_q && !bus.lkup_flush;
    rslt_hit_d = rslt_hit_q;
    rslt_flg_d = rslt_flg_q;
    if (rslt_vld_d) begin
      if (onehot_s) begin
        rslt_hit_d = hit_s;
        rslt_flg_d = sel_flg_s;
      end else begin
        rslt_hit_d = {NUM_REGION{1'b0}};
        rslt_flg_d = DEF_FLG;
      end
    end else begin
      rslt_hit_d = rslt_hit_q;
      rslt_flg_d = rslt_flg_q;
    end
  end

  // Region table and both pipeline stages; reset overrides writes and lookups.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      for (int i = 0; i < NUM_REGION; i++) begin
        upaddr_q[i] <= {ADDR_WIDTH{1'b0}};
        flg_q[i]    <= {FLG_WIDTH{1'b0}};
      end
      s1_vld_q   <= 1'b0;
      s1_lt_q    <= {NUM_REGION{1'b0}};
      rslt_vld_q <= 1'b0;
      rslt_hit_q <= {NUM_REGION{1'b0}};
      rslt_flg_q <= DEF_FLG;
    end else begin
      for (int i = 0; i < NUM_REGION; i++) begin
        upaddr_q[i] <= upaddr_d[i];
        flg_q[i]    <= flg_d[i];
      end
      s1_vld_q   <= s1_vld_d;
      s1_lt_q    <= s1_lt_d;
      rslt_vld_q <= rslt_vld_d;
      rslt_hit_q <= rslt_hit_d;
      rslt_flg_q <= rslt_flg_d;
    end
  end

  assign bus.cfg_rd_upaddr = rd_upaddr_s;
  assign bus.cfg_rd_flg    = rd_flg_s;
  assign bus.rslt_vld      = rslt_vld_q;
  assign bus.rslt_hit      = rslt_hit_q;
  assign bus.rslt_flg      = rslt_flg_q;
endmodule

// File: tb/tb_ct_mmu_sysmap_cfg.sv
// Scoreboard bench for ct_mmu_sysmap_cfg: stimulus queues expected results with their due cycle,
// a negedge monitor pops and compares every presented result.
module tb_ct_mmu_sysmap_cfg;
  localparam int             NR  = 8;
  localparam int             AW  = 28;
  localparam int             FW  = 5;
  localparam logic [FW-1:0]  DEF = 5'b10011;

  typedef struct {
    logic [NR-1:0] hit;
    logic [FW-1:0] flg;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  ct_mmu_sysmap_cfg_if #(.NUM_REGION(NR), .ADDR_WIDTH(AW), .FLG_WIDTH(FW)) bus ();

  ct_mmu_sysmap_cfg #(
    .NUM_REGION(NR), .ADDR_WIDTH(AW), .FLG_WIDTH(FW), .DEF_FLG(DEF)
  ) dut (
    .forever_cpuclk(clk),
    .cpurst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rslt_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rslt: got rslt_vld=1 hit=0x%0h expected no result (cycle %0d)",
                 bus.rslt_hit, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("rslt_cycle", 32'(cyc), 32'(mon_e.due));
        check("rslt_hit", 32'(bus.rslt_hit), 32'(mon_e.hit));
        check("rslt_flg", 32'(bus.rslt_flg), 32'(mon_e.flg));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.lkup_vld   = 1'b0;
    bus.lkup_flush = 1'b0;
    bus.cfg_wen    = 1'b0;
`ifdef SYSMAP_CFG_LOCK_EN
    bus.cfg_lock   = 1'b0;
`endif
  endtask

  task automatic drv_lookup(input logic [AW-1:0] pa, input logic [NR-1:0] eh,
                            input logic [FW-1:0] ef, input bit expect_out);
    bus.lkup_vld = 1'b1;
    bus.lkup_pa  = pa;
    if (expect_out) sb_q.push_back('{hit: eh, flg: ef, due: cyc + 2});
  endtask

  task automatic drv_write(input logic [2:0] idx, input logic [AW-1:0] up, input logic [FW-1:0] fl);
    bus.cfg_wen    = 1'b1;
    bus.cfg_idx    = idx;
    bus.cfg_upaddr = up;
    bus.cfg_flg    = fl;
  endtask

  task automatic rd_check(input logic [2:0] idx, input logic [AW-1:0] up, input logic [FW-1:0] fl);
    bus.cfg_idx = idx;
    @(negedge clk);
    check("rd_upaddr", 32'(bus.cfg_rd_upaddr), 32'(up));
    check("rd_flg", 32'(bus.cfg_rd_flg), 32'(fl));
  endtask

  task automatic chk_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rslt_vld_idle", 32'(bus.rslt_vld), 32'd0);
    end
  endtask

  initial begin
    bus.lkup_vld   = 1'b0;
    bus.lkup_pa    = 28'h0;
    bus.lkup_flush = 1'b0;
    bus.cfg_wen    = 1'b0;
    bus.cfg_idx    = 3'd0;
    bus.cfg_upaddr = 28'h0;
    bus.cfg_flg    = 5'b0;
`ifdef SYSMAP_CFG_LOCK_EN
    bus.cfg_lock   = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_vld", 32'(bus.rslt_vld), 32'd0);
    check("reset_hit", 32'(bus.rslt_hit), 32'd0);
    check("reset_flg", 32'(bus.rslt_flg), 32'(DEF));
    rd_check(3'd0, 28'h0, 5'b0);
    rd_check(3'd7, 28'h0, 5'b0);

    // Empty table: everything misses.
    step();
    drv_lookup(28'h0000123, 8'h00, DEF, 1'b1); step();

    drv_write(3'd0, 28'h0080000, 5'b01111); step();
    drv_write(3'd1, 28'h0100000, 5'b00011); step();
    rd_check(3'd1, 28'h0100000, 5'b00011);
    step();
    drv_lookup(28'h007FFFF, 8'h01, 5'b01111, 1'b1); step();
    drv_lookup(28'h0080000, 8'h02, 5'b00011, 1'b1); step();
    drv_lookup(28'h0000010, 8'h01, 5'b01111, 1'b1); step();
    drv_lookup(28'h0090000, 8'h02, 5'b00011, 1'b1); step();
    drv_lookup(28'h0200000, 8'h00, DEF, 1'b1); step();
    repeat (4) step();

    // Flush kills the in-flight lookup and the one presented with it.
    drv_lookup(28'h0000010, 8'h01, 5'b01111, 1'b0); step();
    bus.lkup_flush = 1'b1;
    drv_lookup(28'h0000010, 8'h01, 5'b01111, 1'b0); step();
    chk_idle(3);

    // Reset with a lookup in flight and a competing write.
    step();
    drv_lookup(28'h0000010, 8'h01, 5'b01111, 1'b0); step();
    rst = 1'b1;
    drv_write(3'd0, 28'h0000555, 5'b11111); step();
    @(negedge clk);
    check("rst_mid_vld", 32'(bus.rslt_vld), 32'd0);
    check("rst_mid_hit", 32'(bus.rslt_hit), 32'd0);
    check("rst_mid_flg", 32'(bus.rslt_flg), 32'(DEF));
    rd_check(3'd0, 28'h0, 5'b0);
    rd_check(3'd1, 28'h0, 5'b0);
    chk_idle(2);

    // Same-cycle write is invisible to the lookup; next cycle sees it.
    step();
    drv_write(3'd0, 28'h0000100, 5'b00111);
    drv_lookup(28'h0000080, 8'h00, DEF, 1'b1); step();
    drv_lookup(28'h0000080, 8'h01, 5'b00111, 1'b1); step();
    drv_write(3'd0, 28'h0000100, 5'b11000);
    drv_lookup(28'h0000080, 8'h01, 5'b11000, 1'b1); step();

    // Exclusive all-ones bound.
    drv_write(3'd0, 28'hFFFFFFF, 5'b01010); step();
    drv_lookup(28'hFFFFFFF, 8'h00, DEF, 1'b1); step();
    drv_lookup(28'hFFFFFFE, 8'h01, 5'b01010, 1'b1); step();

    // Non-monotonic table yields multi-hot -> default.
    drv_write(3'd0, 28'h0000100, 5'b00001); step();
    drv_write(3'd1, 28'h0000050, 5'b00010); step();
    drv_write(3'd2, 28'h0000200, 5'b00100); step();
    drv_lookup(28'h0000060, 8'h00, DEF, 1'b1); step();
    drv_lookup(28'h0000010, 8'h01, 5'b00001, 1'b1); step();
    drv_lookup(28'h0000150, 8'h04, 5'b00100, 1'b1); step();

`ifdef SYSMAP_CFG_LOCK_EN
    drv_write(3'd2, 28'h0000200, 5'b00100);
    bus.cfg_lock = 1'b1;
    step();
    drv_write(3'd2, 28'h0300000, 5'b11111); step();
    rd_check(3'd2, 28'h0000200, 5'b00100);
`endif

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ct_mmu_sysmap_cfg.md
CT_MMU_SYSMAP_CFG -- requirements
Module: ct_mmu_sysmap_cfg

Interface
REQ-001 Parameter NUM_REGION, default 8, number of address regions (2..16).
REQ-002 Parameter ADDR_WIDTH, default 28, PA page-number width (PA[39:12]).
REQ-003 Parameter FLG_WIDTH, default 5, attribute flag width.
REQ-004 Parameter DEF_FLG, default 5'b10011, flag returned when no single region hits.
REQ-005 forever_cpuclk  in  1  sole clock, all state updates on its rising edge.
REQ-006 cpurst  in  1  reset, synchronous and active-high.
REQ-007 lkup_vld  in  1  lookup request valid.
REQ-008 lkup_pa  in  ADDR_WIDTH  lookup physical page number.
REQ-009 lkup_flush  in  1  kills all in-flight lookups.
REQ-010 cfg_wen  in  1  region table write enable.
REQ-011 cfg_idx  in  clog2(NUM_REGION)  region index for write and readback.
REQ-012 cfg_upaddr  in  ADDR_WIDTH  write data, region exclusive upper bound.
REQ-013 cfg_flg  in  FLG_WIDTH  write data, region flag.
REQ-014 cfg_rd_upaddr / cfg_rd_flg  out  ADDR_WIDTH / FLG_WIDTH  combinational readback of entry cfg_idx.
REQ-015 rslt_vld  out  1  lookup result valid.
REQ-016 rslt_hit  out  NUM_REGION  one-hot region hit vector.
REQ-017 rslt_flg  out  FLG_WIDTH  resolved flag.

Function
REQ-018 Region i SHALL cover [upaddr(i-1), upaddr(i)); region 0 lower bound is 0.
REQ-019 Stage 1 SHALL register lkup_vld, a per-region "pa < upaddr(i)" vector, and nothing else derived from the PA.
REQ-020 Stage 2 SHALL form hit(i) = lt(i) & ~lt(i-1) (lt(-1)=0) and register hit vector, flag and valid.
REQ-021 Latency: request at cycle N SHALL produce rslt_vld=1 at cycle N+2; throughput one lookup per cycle, no backpressure.
REQ-022 When hit vector is exactly one-hot, rslt_flg SHALL equal flg of that region and rslt_hit SHALL equal the vector.
REQ-023 When hit vector is zero or multi-hot (non-monotonic table), rslt_flg SHALL equal DEF_FLG and rslt_hit SHALL be all-zero.
REQ-024 rslt_hit and rslt_flg SHALL hold their last value when rslt_vld=0.
REQ-025 Table write SHALL commit at the rising edge where cfg_wen=1; a lookup presented in that same cycle SHALL compare against the pre-write table.
REQ-026 A lookup presented the cycle after a write SHALL see the new table; a lookup already in stage 1 SHALL resolve its flag from the table as of stage 2 entry.
REQ-027 cfg_wen with cfg_idx >= NUM_REGION SHALL be ignored; readback for such index SHALL return zero.
REQ-028 lkup_flush SHALL clear stage-1 and stage-2 valid at the next edge; lkup_vld in the flush cycle SHALL be dropped.
REQ-029 PA equal to upaddr(i) SHALL NOT hit region i (exclusive upper bound); PA all-ones with upaddr all-ones SHALL miss.

Reset
REQ-030 cpurst=1 at a rising edge SHALL clear all upaddr and flg entries to zero, both pipeline valids, rslt_hit to zero and rslt_flg to DEF_FLG.
REQ-031 Reset mid-lookup SHALL drop in-flight lookups; rslt_vld SHALL be 0 in the cycle after reset and until a new request propagates.
REQ-032 cpurst SHALL take priority over cfg_wen and lkup_vld in the same cycle.

Configuration
REQ-033 Macro SYSMAP_CFG_LOCK_EN SHALL add a per-region lock bit, written via cfg_flg write with input cfg_lock=1 (port present only when defined).
REQ-034 With SYSMAP_CFG_LOCK_EN defined, writes to a locked region SHALL be ignored until cpurst; lock bits reset to 0.
REQ-035 Without SYSMAP_CFG_LOCK_EN, no lock state exists and every in-range write commits.

Verification
REQ-036 Reset, then lookup PA 0x0000123 -> cycle+2 rslt_vld=1, rslt_hit=0, rslt_flg=5'b10011.
REQ-037 Program upaddr0=0x0080000 flg0=5'b01111, upaddr1=0x0100000 flg1=5'b00011; lookup 0x007FFFF -> hit=8'h01 flg=01111; lookup 0x0080000 -> hit=8'h02 flg=00011.
REQ-038 Back-to-back lookups 0x10, 0x0090000, 0x0200000 on consecutive cycles -> three consecutive results 8'h01, 8'h02, 8'h00/DEF_FLG.
REQ-039 Write upaddr0=0x0000100 and lookup 0x0000080 in same cycle (old upaddr0=0) -> miss; repeat next cycle -> hit 8'h01.
REQ-040 Lookup then lkup_flush next cycle -> rslt_vld stays 0; cpurst during stage 2 -> rslt_vld=0, table readback all zero.
REQ-041 With SYSMAP_CFG_LOCK_EN, lock region 2 then write upaddr2=0x0300000 -> cfg_rd_upaddr for idx 2 unchanged.
